// File: rtl/alu_result_stage.sv
// Registered result stage behind the combinational alu: flags register, carry feedback and a
// 2-entry writeback FIFO. Optional sticky overflow trap enabled by ALU_RESULT_STAGE_OVF_TRAP_EN.
module alu_result_stage #(
  parameter int unsigned width       = 32,
  parameter int unsigned flags_width = 5,
  parameter int unsigned dst_width   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_wb_en,
  input  logic [dst_width-1:0]   in_dst,
  input  logic [flags_width-1:0] in_flags_mask,
  input  logic [width-1:0]       alu_out,
  input  logic [flags_width-1:0] alu_flags,
  output logic                   carry_out,
  output logic [flags_width-1:0] flags_q,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width-1:0]       out_data,
  output logic [dst_width-1:0]   out_dst,
  output logic                   ovf_trap,
  input  logic                   trap_clr
);

  localparam int unsigned depth = 2;

  typedef struct packed {
    logic [width-1:0]     data;
    logic [dst_width-1:0] dst;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_st_e;

  fifo_st_e st_q, st_d;

  logic   wr_ptr_q, wr_ptr_d;
  logic   rd_ptr_q, rd_ptr_d;
  entry_t mem_q [depth];
  entry_t mem_d [depth];
  entry_t head_q, head_d;

  logic                   out_valid_q, out_valid_d;
  logic [flags_width-1:0] flags_d;

  logic accept_c;
  logic push_c;
  logic pop_c;

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready = (st_q != FULL) | ~in_wb_en;
  assign accept_c = in_valid & in_ready;
  assign push_c   = accept_c & in_wb_en;
  assign pop_c    = out_valid_q & out_ready;

  // FIFO occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= EMPTY;
    end else begin
      st_q <= st_d;
    end
  end

  // FIFO occupancy next state; flush overrides any push/pop
  always_comb begin
    st_d = st_q;
    if (flush) begin
      st_d = EMPTY;
    end else begin
      unique case (st_q)
        EMPTY:   if (push_c) st_d = ONE;
        ONE: begin
          if (push_c && !pop_c)      st_d = FULL;
          else if (pop_c && !push_c) st_d = EMPTY;
        end
        FULL:    if (pop_c) st_d = ONE;
        default: st_d = EMPTY;
      endcase
    end
  end

  // Pointer/storage/head next values derived from the occupancy transition
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push_c) begin
        mem_d[wr_ptr_q] = '{data: alu_out, dst: in_dst};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
    out_valid_d = (st_d != EMPTY);
    head_d      = mem_d[rd_ptr_d];
  end

  // Flags merge under mask; applies even in a flush cycle
  always_comb begin
    flags_d = flags_q;
    if (accept_c) begin
      flags_d = (flags_q & ~in_flags_mask) | (alu_flags & in_flags_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      for (int i = 0; i < int'(depth); i++) begin
        mem_q[i] <= '0;
      end
      head_q      <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      head_q      <= head_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = head_q.data;
  assign out_dst   = head_q.dst;
  assign carry_out = flags_q[0];

`ifdef ALU_RESULT_STAGE_OVF_TRAP_EN
  logic ovf_trap_q, ovf_trap_d;

  // Sticky trap; a new overflow wins over a same-cycle clear
  always_comb begin
    ovf_trap_d = ovf_trap_q;
    if (accept_c && alu_flags[1] && in_flags_mask[1]) begin
      ovf_trap_d = 1'b1;
    end else if (trap_clr) begin
      ovf_trap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_trap_q <= 1'b0;
    end else begin
      ovf_trap_q <= ovf_trap_d;
    end
  end

  assign ovf_trap = ovf_trap_q;
`else
  logic unused_trap_clr;

  assign unused_trap_clr = trap_clr;
  assign ovf_trap        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: directed scenarios plus random traffic against a queue model.
module tb_alu_result_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_wb_en;
  logic [3:0]  in_dst;
  logic [4:0]  in_flags_mask;
  logic [31:0] alu_out;
  logic [4:0]  alu_flags;
  logic        carry_out;
  logic [4:0]  flags_q;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_dst;
  logic        ovf_trap;
  logic        trap_clr;

  alu_result_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wb_en     (in_wb_en),
    .in_dst       (in_dst),
    .in_flags_mask(in_flags_mask),
    .alu_out      (alu_out),
    .alu_flags    (alu_flags),
    .carry_out    (carry_out),
    .flags_q      (flags_q),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_dst      (out_dst),
    .ovf_trap     (ovf_trap),
    .trap_clr     (trap_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: writeback queue, flags register, trap bit
  logic [31:0] q_data[$];
  logic [3:0]  q_dst[$];
  logic [4:0]  m_flags;
  logic        m_trap;
  int          n_vec;
  int          n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_data.delete();
    q_dst.delete();
    m_flags = '0;
    m_trap  = 1'b0;
  endtask

  task automatic check_state();
    chk("out_valid", out_valid, q_data.size() != 0);
    if (q_data.size() != 0) begin
      chk("out_data", out_data, q_data[0]);
      chk("out_dst", out_dst, q_dst[0]);
    end
    chk("flags_q", flags_q, m_flags);
    chk("carry_out", carry_out, m_flags[0]);
    chk("ovf_trap", ovf_trap, m_trap);
  endtask

  // Apply one cycle of inputs at the falling edge, check, then advance the model at the rising edge
  task automatic step(input logic v, input logic wb, input logic [3:0] dst, input logic [4:0] mask,
                      input logic [31:0] data, input logic [4:0] fl, input logic ordy,
                      input logic fsh, input logic tclr);
    logic rdy, acc, pop;
    in_valid = v; in_wb_en = wb; in_dst = dst; in_flags_mask = mask;
    alu_out = data; alu_flags = fl; out_ready = ordy; flush = fsh; trap_clr = tclr;
    #1;
    rdy = (q_data.size() < 2) || !wb;
    chk("in_ready", in_ready, rdy);
    check_state();
    acc = v && rdy;
    pop = (q_data.size() != 0) && ordy;
    @(posedge clk);
    if (acc) m_flags = (m_flags & ~mask) | (fl & mask);
`ifdef ALU_RESULT_STAGE_OVF_TRAP_EN
    if (acc && fl[1] && mask[1]) m_trap = 1'b1;
    else if (tclr)               m_trap = 1'b0;
`else
    m_trap = 1'b0;
`endif
    if (fsh) begin
      q_data.delete();
      q_dst.delete();
    end else begin
      if (pop) begin
        void'(q_data.pop_front());
        void'(q_dst.pop_front());
      end
      if (acc && wb) begin
        q_data.push_back(data);
        q_dst.push_back(dst);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 4'd0, 5'd0, 32'd0, 5'd0, ordy, 1'b0, 1'b0);
  endtask

  task automatic wb_op(input logic [31:0] data, input logic [3:0] dst, input logic ordy);
    step(1'b1, 1'b1, dst, 5'd0, data, 5'd0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_wb_en = 1'b0; in_dst = '0; in_flags_mask = '0; alu_out = '0;
    alu_flags = '0; flush = 1'b0; out_ready = 1'b0; trap_clr = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_dst", out_dst, 4'd0);
    chk("rst_flags", flags_q, 5'd0);
    chk("rst_trap", ovf_trap, 1'b0);
    rst_n = 1'b1;
    in_wb_en = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // ADC chain: carry set then preserved by a mask excluding C
    step(1'b1, 1'b0, 4'd0, 5'b11111, 32'd0, 5'b00001, 1'b0, 1'b0, 1'b0);
    chk("adc_carry1", carry_out, 1'b1);
    step(1'b1, 1'b1, 4'd3, 5'b11110, 32'h5, 5'b00100, 1'b1, 1'b0, 1'b0);
    chk("adc_carry2", carry_out, 1'b1);
    chk("adc_flags2", flags_q, 5'b00101);
    idle(1'b1);

    // Three wb ops against a stalled consumer, then drain in order
    wb_op(32'h11, 4'd1, 1'b0);
    wb_op(32'h22, 4'd2, 1'b0);
    chk("full_stall", in_ready, 1'b0);
    wb_op(32'h33, 4'd3, 1'b0);
    chk("order0", out_data, 32'h11);
    wb_op(32'h33, 4'd3, 1'b1);   // full + pop: no push this cycle
    chk("order1", out_data, 32'h22);
    wb_op(32'h33, 4'd3, 1'b1);   // push lands, head replaced at ONE
    chk("order2", out_data, 32'h33);
    chk("order2_dst", out_dst, 4'd3);
    idle(1'b1);
    chk("drained", out_valid, 1'b0);

    // Flush at count=2 with a same-cycle flags-only op
    wb_op(32'hA1, 4'd5, 1'b0);
    wb_op(32'hA2, 4'd6, 1'b0);
    step(1'b1, 1'b0, 4'd0, 5'b00100, 32'd0, 5'b00100, 1'b1, 1'b1, 1'b0);
    chk("flush2_valid", out_valid, 1'b0);
    chk("flush2_z", flags_q[2], 1'b1);
    // Flush at count=1 with a same-cycle wb accept: entry discarded, flags kept
    wb_op(32'hB1, 4'd7, 1'b0);
    step(1'b1, 1'b1, 4'd8, 5'b00101, 32'hB2, 5'b00100, 1'b0, 1'b1, 1'b0);
    chk("flush1_valid", out_valid, 1'b0);
    chk("flush1_flags", flags_q, 5'b00100);
    idle(1'b0);

    // Overflow trap: set, hold, set-beats-clear, clear
    step(1'b1, 1'b0, 4'd0, 5'b00010, 32'd0, 5'b00010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b0);
    step(1'b1, 1'b0, 4'd0, 5'b00010, 32'd0, 5'b00010, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    step(1'b0, 1'b0, 4'd0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    // Mask 0 no-op leaves flags alone
    step(1'b1, 1'b0, 4'd0, 5'b00000, 32'd0, 5'b11111, 1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 4'($urandom),
           5'($urandom), $urandom, 5'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset mid-stream with the FIFO full and flags non-zero
    step(1'b1, 1'b0, 4'd0, 5'b11111, 32'd0, 5'b10101, 1'b0, 1'b0, 1'b0);
    wb_op(32'hC1, 4'd1, 1'b0);
    wb_op(32'hC2, 4'd2, 1'b0);
    check_state();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_flags", flags_q, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_wb_en = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    wb_op(32'hD1, 4'd9, 1'b0);
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
